// File: rtl/alu_dispatch.sv
// alu_dispatch: 4-entry request FIFO feeding four round-robin ALU lanes.
// A popped request is written into the lane fields of lane rr_ptr. The lane
// result comes back through alu_d two edges after issue, and the block
// returns it as a one-cycle out_valid pulse.
// Optional feature: define ALU_DISPATCH_DIVZERO_TRAP_EN to trap divides by
// zero (err pulse, no lane write, no result) instead of issuing them.
//
// Handshake: a request transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready depends only on the registered occupancy, so
// a full FIFO refuses pushes even when a pop happens at the same edge.
// Results have no backpressure.
module alu_dispatch (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_a,
  input  logic [3:0]  in_b,
  input  logic [5:0]  in_op,
  output logic [15:0] lane_a,
  output logic [15:0] lane_b,
  output logic [23:0] lane_s,
  output logic [1:0]  sel,
  input  logic [7:0]  alu_d,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic [1:0]  out_lane,
  output logic        busy,
  output logic [2:0]  count,
  output logic        err,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // FIFO entry layout: {a[3:0], b[3:0], op[5:0]}
  logic [13:0] fifo_mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q, rr_ptr_q;
  logic [2:0]  count_q, count_d;
  logic [1:0]  state_q, state_d;

  logic [15:0] lane_a_q, lane_b_q;
  logic [23:0] lane_s_q;

  // Pipeline: stage 1 is the cycle after issue, stage 2 the cycle with sel.
  logic        p1_valid_q, p2_valid_q;
  logic [1:0]  p1_lane_q;
  logic [1:0]  sel_lane_q;

  logic        out_valid_q;
  logic [7:0]  out_data_q;
  logic [1:0]  out_lane_q;

  logic        push, pop, issue;
  logic [13:0] head;
  logic [3:0]  head_a, head_b;
  logic [5:0]  head_op;

  assign in_ready = (count_q < 3'd4);
  assign push     = in_valid && in_ready;
  assign pop      = issue_en && (count_q != 3'd0);

  assign head    = fifo_mem_q[rd_ptr_q];
  assign head_a  = head[13:10];
  assign head_b  = head[9:6];
  assign head_op = head[5:0];

`ifdef ALU_DISPATCH_DIVZERO_TRAP_EN
  logic trap;
  logic err_q;

  // Arithmetic divide ({op0,op1} = 1) with a zero divisor is trapped at pop.
  assign trap  = pop && !head_op[5] && !head_op[0] && head_op[1] && (head_b == 4'd0);
  assign issue = pop && !trap;
  assign err   = err_q;

  // One-cycle trap pulse, registered at the edge the trapped entry pops.
  always_ff @(posedge clk) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= trap;
  end
`else
  assign issue = pop;
  assign err   = 1'b0;
`endif

  // Occupancy next-state: simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (!push && pop) count_d = count_q - 3'd1;
  end

  // FSM next-state: DRAIN leaves for IDLE at the edge that retires the last
  // in-flight result (nothing left in stage 1).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (push) state_d = ST_ISSUE;
      ST_ISSUE: if (count_d == 3'd0) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (push)             state_d = ST_ISSUE;
        else if (!p1_valid_q) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // FIFO storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {in_a, in_b, in_op};
  end

  // Control state, lane fields, result pipeline and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      rr_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      state_q     <= ST_IDLE;
      lane_a_q    <= 16'd0;
      lane_b_q    <= 16'd0;
      lane_s_q    <= 24'd0;
      p1_valid_q  <= 1'b0;
      p1_lane_q   <= 2'd0;
      p2_valid_q  <= 1'b0;
      sel_lane_q  <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_lane_q  <= 2'd0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      if (issue) begin
        rr_ptr_q  <= rr_ptr_q + 2'd1;
        p1_lane_q <= rr_ptr_q;
      end
      for (int l = 0; l < 4; l++) begin
        if (issue && (rr_ptr_q == 2'(l))) begin
          lane_a_q[4*l +: 4] <= head_a;
          lane_b_q[4*l +: 4] <= head_b;
          lane_s_q[6*l +: 6] <= head_op;
        end
      end
      p1_valid_q <= issue;
      p2_valid_q <= p1_valid_q;
      if (p1_valid_q) sel_lane_q <= p1_lane_q;
      out_valid_q <= p2_valid_q;
      if (p2_valid_q) begin
        out_data_q <= alu_d;
        out_lane_q <= sel_lane_q;
      end
    end
  end

  assign lane_a    = lane_a_q;
  assign lane_b    = lane_b_q;
  assign lane_s    = lane_s_q;
  // The ALU array expects the lane index bit-reversed on sel.
  assign sel       = {sel_lane_q[0], sel_lane_q[1]};
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
  assign count     = count_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: directed bench for alu_dispatch with a behavioural
// ALU array model driving alu_d from the registered lane fields and sel.
module tb_alu_dispatch;

  logic        clk, reset, issue_en, in_valid, in_ready;
  logic [3:0]  in_a, in_b;
  logic [5:0]  in_op;
  logic [15:0] lane_a, lane_b;
  logic [23:0] lane_s;
  logic [1:0]  sel;
  logic [7:0]  alu_d;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_lane;
  logic        busy;
  logic [2:0]  count;
  logic        err;
  logic [1:0]  dbg_state;

  alu_dispatch dut (
    .clk(clk), .reset(reset), .issue_en(issue_en), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .lane_a(lane_a), .lane_b(lane_b), .lane_s(lane_s), .sel(sel),
    .alu_d(alu_d), .out_valid(out_valid), .out_data(out_data),
    .out_lane(out_lane), .busy(busy), .count(count), .err(err),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [5:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];
  vec_t seq_a [5];
  vec_t seq_b [5];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        mon_en   = 1'b0;
  logic [9:0]  exp_q [$];          // {lane[1:0], data[7:0]}
  int          out_cyc [$];
  logic [1:0]  prev_sel;
  logic [1:0]  exp_rr;
  logic [15:0] exp_lane_a, exp_lane_b;
  logic [23:0] exp_lane_s;
  logic [7:0]  res_q [4];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- ALU array model ----------------
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [5:0] s);
    logic [7:0] r;
    if (!s[5]) begin
      case ({s[0], s[1]})
        2'd0:    r = {4'd0, a} * {4'd0, b};
        2'd1:    r = (b == 4'd0) ? 8'hFF : {4'd0, a / b};
        2'd2:    r = {4'd0, a} + {4'd0, b};
        default: r = {4'd0, a} - {4'd0, b};
      endcase
    end else begin
      case ({s[2], s[3], s[4]})
        3'd0:    r = {4'd0, a & b};
        3'd1:    r = {4'd0, a | b};
        3'd2:    r = {4'd0, a ^ b};
        default: r = {4'd0, ~(a & b)};
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      res_q[l] <= alu_f(lane_a[4*l +: 4], lane_b[4*l +: 4], lane_s[6*l +: 6]);
  end

  assign alu_d = res_q[{sel[0], sel[1]}];

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input vec_t v);
    in_a     = v.a;
    in_b     = v.b;
    in_op    = v.op;
    in_valid = 1'b1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    issue_en = 1'b0;
    step();
    step();
    exp_q.delete();
    out_cyc.delete();
    reset = 1'b1;
    step();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_all_results", 32'(exp_q.size()), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [9:0] item;
    prev_sel = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en && out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got lane %0d data 0x%0h, required no result",
                   out_lane, out_data);
        end else begin
          item = exp_q.pop_front();
          check("sb_out_lane", 32'(out_lane), 32'(item[9:8]));
          check("sb_out_data", 32'(out_data), 32'(item[7:0]));
          check("sb_sel_before_result", 32'(prev_sel), 32'({item[8], item[9]}));
          out_cyc.push_back(cyc);
        end
      end
      prev_sel = sel;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b0; issue_en = 1'b0; in_valid = 1'b0;
    in_a = 4'd0; in_b = 4'd0; in_op = 6'd0;

    vecs[0] = '{a: 4'd6, b: 4'd3, op: 6'b000001, exp: 8'h09};  // add
    vecs[1] = '{a: 4'd7, b: 4'd5, op: 6'b000000, exp: 8'h23};  // mul
    vecs[2] = '{a: 4'd3, b: 4'd5, op: 6'b000011, exp: 8'hFE};  // sub wraps
    vecs[3] = '{a: 4'hC, b: 4'h3, op: 6'b110000, exp: 8'h0F};  // or
    vecs[4] = '{a: 4'hF, b: 4'h5, op: 6'b101000, exp: 8'h0A};  // xor
    vecs[5] = '{a: 4'd9, b: 4'd2, op: 6'b000010, exp: 8'h04};  // div
    vecs[6] = '{a: 4'hF, b: 4'hF, op: 6'b000001, exp: 8'h1E};  // add max
    vecs[7] = '{a: 4'd0, b: 4'd9, op: 6'b000000, exp: 8'h00};  // mul zero

    seq_a[0] = '{a: 4'hF, b: 4'hF, op: 6'b000000, exp: 8'hE1};
    seq_a[1] = '{a: 4'hC, b: 4'hA, op: 6'b100000, exp: 8'h08};
    seq_a[2] = '{a: 4'd1, b: 4'd1, op: 6'b000001, exp: 8'h02};
    seq_a[3] = '{a: 4'd2, b: 4'd2, op: 6'b000001, exp: 8'h04};
    seq_a[4] = '{a: 4'd3, b: 4'd3, op: 6'b000001, exp: 8'h06};

    seq_b[0] = '{a: 4'd1, b: 4'd2, op: 6'b000001, exp: 8'h03};
    seq_b[1] = '{a: 4'd9, b: 4'd4, op: 6'b000011, exp: 8'h05};
    seq_b[2] = '{a: 4'd3, b: 4'd4, op: 6'b000000, exp: 8'h0C};
    seq_b[3] = '{a: 4'hF, b: 4'h6, op: 6'b100000, exp: 8'h06};
    seq_b[4] = '{a: 4'd7, b: 4'd7, op: 6'b000001, exp: 8'h0E};

    // Reset state
    step();
    step();
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_lane", 32'(out_lane), 0);
    check("rst_lane_a", 32'(lane_a), 0);
    check("rst_lane_b", 32'(lane_b), 0);
    check("rst_lane_s", 32'(lane_s), 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_state", 32'(dbg_state), 0);
    reset = 1'b1;
    step();
    check("rst_release_in_ready", 32'(in_ready), 1);

    // Single requests, one at a time, walking the round-robin pointer
    exp_rr = 2'd0;
    exp_lane_a = '0; exp_lane_b = '0; exp_lane_s = '0;
    issue_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_req(vecs[i]);
      step();                                    // push edge
      in_valid = 1'b0;
      check("vec_count_after_push", 32'(count), 1);
      check("vec_busy_after_push", 32'(busy), 1);
      step();                                    // issue edge
      exp_lane_a[4*int'(exp_rr) +: 4] = vecs[i].a;
      exp_lane_b[4*int'(exp_rr) +: 4] = vecs[i].b;
      exp_lane_s[6*int'(exp_rr) +: 6] = vecs[i].op;
      check("vec_lane_a", 32'(lane_a), 32'(exp_lane_a));
      check("vec_lane_b", 32'(lane_b), 32'(exp_lane_b));
      check("vec_lane_s", 32'(lane_s), 32'(exp_lane_s));
      check("vec_count_after_issue", 32'(count), 0);
      check("vec_state_drain", 32'(dbg_state), 2);
      step();
      check("vec_sel", 32'(sel), 32'({exp_rr[0], exp_rr[1]}));
      check("vec_no_early_valid", 32'(out_valid), 0);
      step();                                    // issue + 2
      check("vec_out_valid", 32'(out_valid), 1);
      check("vec_out_data", 32'(out_data), 32'(vecs[i].exp));
      check("vec_out_lane", 32'(out_lane), 32'(exp_rr));
      exp_rr = exp_rr + 2'd1;
      step();
      check("vec_valid_one_cycle", 32'(out_valid), 0);
      check("vec_state_idle", 32'(dbg_state), 0);
    end

    // Back-to-back pushes: consecutive results, sel 00,10,01,11, fifth to lane 0
    do_reset();
    mon_en   = 1'b1;
    issue_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({2'(k % 4), seq_a[k].exp});
      push_req(seq_a[k]);
      step();
      check("b2b_count_steady", 32'(count), 1);
    end
    in_valid = 1'b0;
    wait_drain(20);
    check("b2b_result_count", 32'(out_cyc.size()), 5);
    for (int k = 1; k < out_cyc.size(); k++)
      check("b2b_consecutive", 32'(out_cyc[k] - out_cyc[0]), 32'(k));

    // Stalled issue fills the FIFO; fifth push refused, also with a same-edge pop
    do_reset();
    issue_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push_req(seq_b[k]);
      check("full_in_ready", 32'(in_ready), (k < 4) ? 1 : 0);
      if (k < 4) exp_q.push_back({2'(k), seq_b[k].exp});
      step();
      check("full_count", 32'(count), (k < 4) ? k + 1 : 4);
    end
    check("full_state_issue_hold", 32'(dbg_state), 1);
    issue_en = 1'b1;                             // in_valid still 1, FIFO full
    step();
    in_valid = 1'b0;
    check("full_pop_no_push", 32'(count), 3);
    wait_drain(20);
    step();
    check("full_count_empty", 32'(count), 0);
    check("full_state_idle", 32'(dbg_state), 0);
    check("full_busy_clear", 32'(busy), 0);

    // Reset mid-operation: three queued, one in flight
    do_reset();
    issue_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_req(seq_b[k]);
      step();
    end
    in_valid = 1'b0;
    issue_en = 1'b1;
    step();
    issue_en = 1'b0;
    check("midrst_count_before", 32'(count), 3);
    reset = 1'b0;
    step();
    check("midrst_count", 32'(count), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_lane_a", 32'(lane_a), 0);
    check("midrst_lane_b", 32'(lane_b), 0);
    check("midrst_lane_s", 32'(lane_s), 0);
    check("midrst_busy", 32'(busy), 0);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("midrst_no_result", 32'(out_valid), 0);
    end

    // Divide by zero
    do_reset();
    issue_en = 1'b1;
    push_req('{a: 4'd8, b: 4'd0, op: 6'b000010, exp: 8'hFF});
`ifdef ALU_DISPATCH_DIVZERO_TRAP_EN
    step();
    in_valid = 1'b0;
    step();                                      // trapped pop
    check("div0_err_pulse", 32'(err), 1);
    check("div0_no_lane_write", 32'(lane_s), 0);
    step();
    check("div0_err_one_cycle", 32'(err), 0);
    exp_q.push_back({2'd0, 8'h03});              // rr_ptr still on lane 0
    push_req('{a: 4'd1, b: 4'd2, op: 6'b000001, exp: 8'h03});
    step();
    in_valid = 1'b0;
    wait_drain(10);
`else
    exp_q.push_back({2'd0, 8'hFF});
    step();
    in_valid = 1'b0;
    step();                                      // issue edge
    check("div0_lane_s", 32'(lane_s[5:0]), 32'(6'b000010));
    check("div0_lane_b", 32'(lane_b[3:0]), 0);
    check("div0_err_tied", 32'(err), 0);
    step();
    check("div0_no_early_valid", 32'(out_valid), 0);
    step();
    check("div0_valid_at_2", 32'(out_valid), 1);
    wait_drain(10);
`endif
    for (int k = 0; k < 3; k++) step();
    check("final_state_idle", 32'(dbg_state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 The block SHALL have port: clk  in  1  single clock; all state updates on posedge clk.
REQ-002 The block SHALL have port: reset  in  1  synchronous, active-low reset (sampled on posedge clk, active when 0).
REQ-003 The block SHALL have port: issue_en  in  1  issue enable; 0 stalls FIFO pops, 1 allows one pop per cycle.
REQ-004 The block SHALL have port: in_valid  in  1  request valid.
REQ-005 The block SHALL have port: in_ready  out  1  request accepted when in_valid and in_ready are both 1 at posedge clk.
REQ-006 The block SHALL have port: in_a, in_b  in  4 each  operands.
REQ-007 The block SHALL have port: in_op  in  6  ALU lane select word; bit5=0 arithmetic, with {bit0,bit1} 0=mul, 1=div, 2=add, 3=sub; bit5=1 logic, with {bit2,bit3,bit4} selecting the op.
REQ-008 The block SHALL have port: lane_a, lane_b  out  16 each  lane L operands on bits [4L+3:4L].
REQ-009 The block SHALL have port: lane_s  out  24  lane L select on bits [6L+5:6L].
REQ-010 The block SHALL have port: sel  out  2  result-mux select to the ALU array; sel[1]=lane[0], sel[0]=lane[1].
REQ-011 The block SHALL have port: alu_d  in  8  selected registered lane result.
REQ-012 The block SHALL have ports: out_valid  out  1 (one-cycle result pulse), out_data  out  8 (result), out_lane  out  2 (result lane).
REQ-013 The block SHALL have ports: busy  out  1 (state != IDLE), count  out  3 (FIFO occupancy 0..4), err  out  1 (one-cycle trap pulse).

Function
REQ-014 The block SHALL buffer requests in a 4-entry FIFO of {a,b,op}; in_ready = (count < 4); a push when full SHALL be impossible, even if a pop occurs in the same cycle.
REQ-015 The FIFO SHALL have no bypass: an entry pushed at edge N SHALL pop at edge N+1 at the earliest.
REQ-016 At an edge where issue_en=1 and count>0, the block SHALL pop the head and register it into lane rr_ptr's lane_a/lane_b/lane_s fields; rr_ptr SHALL then increment mod 4 (3 wraps to 0).
REQ-017 Lane fields SHALL hold their value until that lane is next issued; other lanes SHALL be unchanged.
REQ-018 Issue at edge N SHALL drive sel for that lane during cycle N+1..N+2; at edge N+2, out_data=alu_d, out_lane=lane, and out_valid=1 for one cycle (fixed latency 2, no output backpressure).
REQ-019 Simultaneous push and pop SHALL leave count unchanged; count SHALL never exceed 4 or underflow.
REQ-020 The FSM SHALL have states IDLE (FIFO and pipeline empty), ISSUE (count>0), and DRAIN (count=0 with a result in flight).
REQ-021 FSM transitions SHALL be: IDLE->ISSUE on push; ISSUE->DRAIN when the last entry pops; DRAIN->ISSUE on push; DRAIN->IDLE when the pipeline is empty; ISSUE with issue_en=0 SHALL hold.

Reset
REQ-022 With reset=0 at posedge clk, the block SHALL clear: FIFO empty, count=0, rr_ptr=0, all lane fields 0, sel=0, out_valid=0, out_data=0, out_lane=0, err=0, state IDLE.
REQ-023 in_ready SHALL be 1 in the cycle after reset releases.
REQ-024 A reset mid-operation SHALL discard queued and in-flight requests, and no out_valid SHALL follow for them.

Configuration
REQ-025 With macro ALU_DISPATCH_DIVZERO_TRAP_EN defined, a popped divide (bit5=0, bit0=0, bit1=1) with b=0 SHALL not be written to a lane and SHALL not advance rr_ptr; err SHALL pulse 1 at the next edge, and no out_valid SHALL be produced for it.
REQ-026 Without ALU_DISPATCH_DIVZERO_TRAP_EN, such an op SHALL be issued like any other, and err SHALL be tied 0.

Verification
REQ-027 The bench SHALL check: reset, then push a=6, b=3, op=6'b000001 (add) with issue_en=1 -> lane 0 issued; 2 cycles after issue, out_valid=1, out_data=9, out_lane=0.
REQ-028 The bench SHALL check: four back-to-back pushes mul 15*15, and (op 6'b100000) 0xC&0xA, add 1+1, add 2+2 -> out_lane 0,1,2,3 with out_data 0xE1, 0x08, 2, 4 on consecutive cycles; sel sequence 00, 10, 01, 11; a fifth push goes to lane 0.
REQ-029 The bench SHALL check: issue_en=0 with 5 push attempts -> count=4, in_ready=0, 5th not accepted; then issue_en=1 -> 4 results, count returns to 0, FSM ends in IDLE.
REQ-030 The bench SHALL check: reset=0 asserted with count=3 and one result in flight -> next cycle count=0, out_valid stays 0, all lane fields 0.
REQ-031 The bench SHALL check: divide a=8, b=0 -> with the macro, err=1 for one cycle, no out_valid, rr_ptr unchanged; without the macro, issued to lane rr_ptr and out_valid=1 at +2.
